out_sched: RTL and testbench

Stereo output scheduler between the two filter-datapath ALUs and the left/right P2S serializers. It collects independently completed 40-bit left and right results into pairs and buffers the pairs in a small FIFO. On each accepted FRAME rising edge it retires the head pair, having already presented that pair as stable PDATAIN to both P2S instances. Running dry at a frame is flagged and does not stall the serializers.

---
 rtl/out_sched_if.sv | 27 ++
 rtl/out_sched.sv | 133 +++++++++++++
 tb/tb_out_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/out_sched_if.sv
// Stereo result / serializer data bundle for out_sched.
//   IN_L_VALID/IN_R_VALID, IN_L_DATA/IN_R_DATA : result source -> scheduler
//   IN_L_READY/IN_R_READY                      : scheduler -> result source
//   PDATA_L/PDATA_R                            : scheduler -> P2S PDATAIN
// Handshake: a word transfers on a rising clock edge where VALID and READY
// are both high; while VALID is high and READY low the source holds its data.
// master = result source / P2S side, slave = out_sched.
interface out_sched_if;
  logic        IN_L_VALID;
  logic        IN_R_VALID;
  logic [39:0] IN_L_DATA;
  logic [39:0] IN_R_DATA;
  logic        IN_L_READY;
  logic        IN_R_READY;
  logic [39:0] PDATA_L;
  logic [39:0] PDATA_R;

  modport master (
    output IN_L_VALID, IN_R_VALID, IN_L_DATA, IN_R_DATA,
    input  IN_L_READY, IN_R_READY, PDATA_L, PDATA_R
  );

  modport slave (
    input  IN_L_VALID, IN_R_VALID, IN_L_DATA, IN_R_DATA,
    output IN_L_READY, IN_R_READY, PDATA_L, PDATA_R
  );
endinterface

// File: rtl/out_sched.sv
// Stereo output scheduler: pairs independently completed left/right results,
// buffers the pairs in a DEPTH-entry FIFO and presents the FIFO head as
// registered PDATA_L/PDATA_R. Each accepted FRAME rising edge retires the head.
// Ports:
//   SCLK, CLR_N (async, active-low), EN (global clock enable)
//   FRAME, P2S_BUSY : frame strobe and serializer busy (gates frame accept)
//   UFLOW_CLR       : synchronous clear of UNDERFLOW
//   FILL            : FIFO occupancy in pairs
//   UNDERFLOW       : sticky, a frame was accepted with the FIFO empty
//   bus (slave)     : result handshakes and PDATA outputs
// Build option: define OUT_SCHED_HOLD_EN to keep the last popped pair on
// PDATA when the FIFO is empty (P2S repeats the previous sample) instead of 0.
module out_sched #(
  parameter int DEPTH = 4
) (
  input  logic                     SCLK,
  input  logic                     CLR_N,
  input  logic                     EN,
  input  logic                     FRAME,
  input  logic                     P2S_BUSY,
  input  logic                     UFLOW_CLR,
  output logic [$clog2(DEPTH):0]   FILL,
  output logic                     UNDERFLOW,
  out_sched_if.slave               bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic          held_l, held_r;
  logic [39:0]   hold_l_data, hold_r_data;
  logic [39:0]   mem_l [DEPTH];
  logic [39:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [FW-1:0] fill;
  logic          frame_d;
  logic [39:0]   pdata_l, pdata_r;
  logic [39:0]   head_l_n, head_r_n;
  logic          accept_l, accept_r, commit, fa, pop;

  assign bus.IN_L_READY = EN & ~held_l;
  assign bus.IN_R_READY = EN & ~held_r;
  assign accept_l = bus.IN_L_VALID & bus.IN_L_READY;
  assign accept_r = bus.IN_R_VALID & bus.IN_R_READY;

  // Full check uses the occupancy before any pop in the same cycle.
  assign commit  = EN & held_l & held_r & (fill < FW'(DEPTH));
  assign fa      = EN & FRAME & ~frame_d & ~P2S_BUSY;
  assign pop     = fa & (fill != '0);
  assign rd_next = rd_ptr + 1'b1;

  assign bus.PDATA_L = pdata_l;
  assign bus.PDATA_R = pdata_r;
  assign FILL        = fill;

  // Head after this cycle's push/pop. The array is written at the same edge,
  // so a commit that lands in the head slot is taken from the holding regs.
  always_comb begin
    head_l_n = pdata_l;
    head_r_n = pdata_r;
    if (commit && fill == '0) begin
      head_l_n = hold_l_data;
      head_r_n = hold_r_data;
    end else if (pop) begin
      if (fill == FW'(1)) begin
        if (commit) begin
          head_l_n = hold_l_data;
          head_r_n = hold_r_data;
        end else begin
`ifdef OUT_SCHED_HOLD_EN
          head_l_n = pdata_l;
          head_r_n = pdata_r;
`else
          head_l_n = '0;
          head_r_n = '0;
`endif
        end
      end else begin
        head_l_n = mem_l[rd_next];
        head_r_n = mem_r[rd_next];
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (commit) begin
      mem_l[wr_ptr] <= hold_l_data;
      mem_r[wr_ptr] <= hold_r_data;
    end
  end

  always_ff @(posedge SCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      held_l      <= 1'b0;
      held_r      <= 1'b0;
      hold_l_data <= '0;
      hold_r_data <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      frame_d     <= 1'b0;
      pdata_l     <= '0;
      pdata_r     <= '0;
      UNDERFLOW   <= 1'b0;
    end else begin
      // Accept and commit never coincide on a channel: READY is low while held.
      if (accept_l) begin
        held_l      <= 1'b1;
        hold_l_data <= bus.IN_L_DATA;
      end else if (commit) begin
        held_l <= 1'b0;
      end
      if (accept_r) begin
        held_r      <= 1'b1;
        hold_r_data <= bus.IN_R_DATA;
      end else if (commit) begin
        held_r <= 1'b0;
      end

      if (commit) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_next;
      fill <= fill + {{AW{1'b0}}, commit} - {{AW{1'b0}}, pop};

      if (EN) frame_d <= FRAME;

      pdata_l <= head_l_n;
      pdata_r <= head_r_n;

      // Set wins over a coincident clear.
      if (fa && fill == '0)      UNDERFLOW <= 1'b1;
      else if (EN && UFLOW_CLR)  UNDERFLOW <= 1'b0;
    end
  end
endmodule

// File: tb/tb_out_sched.sv
// Self-checking bench for out_sched: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_out_sched;
  localparam int DEPTH = 4;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          SCLK = 1'b0;
  logic          CLR_N;
  logic          EN;
  logic          FRAME;
  logic          P2S_BUSY;
  logic          UFLOW_CLR;
  logic [FW-1:0] FILL;
  logic          UNDERFLOW;

  out_sched_if bus();

  out_sched #(.DEPTH(DEPTH)) dut (
    .SCLK      (SCLK),
    .CLR_N     (CLR_N),
    .EN        (EN),
    .FRAME     (FRAME),
    .P2S_BUSY  (P2S_BUSY),
    .UFLOW_CLR (UFLOW_CLR),
    .FILL      (FILL),
    .UNDERFLOW (UNDERFLOW),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  always #5 SCLK = ~SCLK;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: FIFO of {left,right} pairs plus per-channel holding slots.
  logic [79:0] exp_q[$];
  bit          m_hl = 1'b0, m_hr = 1'b0;
  logic [39:0] m_ld = '0, m_rd = '0;
  bit          m_fd = 1'b0, m_uf = 1'b0;
  logic [79:0] m_last = '0;
  bit          acc_l_last = 1'b0, acc_r_last = 1'b0;
  bit          m_al, m_ar, m_cm, m_fa;
  logic [79:0] chk_head;

  function automatic logic [79:0] exp_head();
    if (exp_q.size() > 0) return exp_q[0];
`ifdef OUT_SCHED_HOLD_EN
    return m_last;
`else
    return '0;
`endif
  endfunction

  always @(posedge SCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      exp_q.delete();
      m_hl = 1'b0; m_hr = 1'b0; m_fd = 1'b0; m_uf = 1'b0; m_last = '0;
      acc_l_last = 1'b0; acc_r_last = 1'b0;
    end else begin
      m_al = bus.IN_L_VALID && EN && !m_hl;
      m_ar = bus.IN_R_VALID && EN && !m_hr;
      m_cm = EN && m_hl && m_hr && (exp_q.size() < DEPTH);
      m_fa = EN && FRAME && !m_fd && !P2S_BUSY;
      if (m_fa && exp_q.size() == 0) m_uf = 1'b1;
      else if (EN && UFLOW_CLR)      m_uf = 1'b0;
      if (m_fa && exp_q.size() > 0) m_last = exp_q.pop_front();
      if (m_cm) begin
        exp_q.push_back({m_ld, m_rd});
        m_hl = 1'b0; m_hr = 1'b0;
      end
      if (m_al) begin m_hl = 1'b1; m_ld = bus.IN_L_DATA; end
      if (m_ar) begin m_hr = 1'b1; m_rd = bus.IN_R_DATA; end
      if (EN) m_fd = FRAME;
      acc_l_last = m_al;
      acc_r_last = m_ar;
    end
  end

  // Compare every output on the falling edge, before the driver moves inputs.
  always @(negedge SCLK) begin
    if (CLR_N) begin
      chk_head = exp_head();
      check("fill",      64'(FILL),           64'(exp_q.size()));
      check("pdata_l",   64'(bus.PDATA_L),    64'(chk_head[79:40]));
      check("pdata_r",   64'(bus.PDATA_R),    64'(chk_head[39:0]));
      check("underflow", 64'(UNDERFLOW),      64'(m_uf));
      check("ready_l",   64'(bus.IN_L_READY), 64'(EN && !m_hl));
      check("ready_r",   64'(bus.IN_R_READY), 64'(EN && !m_hr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit lv, input logic [39:0] ld, input bit rv,
                       input logic [39:0] rd, input bit fr, input bit busy,
                       input bit uclr, input bit en);
    @(negedge SCLK);
    #1;
    bus.IN_L_VALID = lv;
    bus.IN_L_DATA  = ld;
    bus.IN_R_VALID = rv;
    bus.IN_R_DATA  = rd;
    FRAME          = fr;
    P2S_BUSY       = busy;
    UFLOW_CLR      = uclr;
    EN             = en;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic frame_pulse();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sample();
    @(negedge SCLK);
    #1;
  endtask

  function automatic logic [39:0] rand40();
    return {8'($urandom), $urandom};
  endfunction

  // ---------------- stimulus ----------------
  logic [39:0] l_word, r_word;
  bit          lv, rv, fr, busy, uclr, en;
  int          frame_div;

  initial begin
    bus.IN_L_VALID = 1'b0; bus.IN_R_VALID = 1'b0;
    bus.IN_L_DATA  = '0;   bus.IN_R_DATA  = '0;
    FRAME = 1'b0; P2S_BUSY = 1'b0; UFLOW_CLR = 1'b0; EN = 1'b0;
    CLR_N = 1'b0;

    // Reset: READY follows EN even while CLR_N is low.
    #3;
    check("rst_ready_en0", 64'(bus.IN_L_READY), 64'd0);
    EN = 1'b1;
    #1;
    check("rst_ready_en1", 64'(bus.IN_R_READY), 64'd1);
    check("rst_fill",      64'(FILL),           64'd0);
    check("rst_pdata",     64'(bus.PDATA_L),    64'd0);
    check("rst_uflow",     64'(UNDERFLOW),      64'd0);
    repeat (2) @(negedge SCLK);
    #1 CLR_N = 1'b1;

    // Basic pair: L on cycle 0, R on cycle 3, visible from cycle 5.
    drive(1'b1, 40'h12_3456_789A, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(1'b0, '0, 1'b1, 40'hFF_0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    sample();
    check("basic_pdata_l", 64'(bus.PDATA_L), 64'h12_3456_789A);
    check("basic_pdata_r", 64'(bus.PDATA_R), 64'hFF_0000_0001);
    check("basic_fill1",   64'(FILL),        64'd1);
    frame_pulse();
    sample();
    check("basic_fill0",   64'(FILL),        64'd0);
    check("basic_uflow",   64'(UNDERFLOW),   64'd0);

    // Fill to full: 5 pairs, the last one stays in the holding registers.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rand40(), 1'b1, rand40(), 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
    end
    sample();
    check("full_fill",    64'(FILL),           64'd4);
    check("full_ready_l", 64'(bus.IN_L_READY), 64'd0);
    check("full_ready_r", 64'(bus.IN_R_READY), 64'd0);
    frame_pulse();
    idle(1);
    sample();
    check("full_refill",  64'(FILL),           64'd4);
    check("full_drained", 64'(bus.IN_L_READY), 64'd1);

    // Asynchronous reset mid-operation with FILL=3.
    frame_pulse();
    sample();
    check("mid_fill3", 64'(FILL), 64'd3);
    #2 CLR_N = 1'b0;
    #1;
    check("mid_rst_fill",  64'(FILL),           64'd0);
    check("mid_rst_pdata", 64'(bus.PDATA_R),    64'd0);
    check("mid_rst_ready", 64'(bus.IN_L_READY), 64'(EN));
    @(negedge SCLK);
    #1 CLR_N = 1'b1;

    // Busy and EN gating: frame edges cause no pop.
    drive(1'b1, rand40(), 1'b1, rand40(), 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    sample();
    check("gate_fill", 64'(FILL), 64'd1);

    // Underflow: set, clear, and set winning over a coincident clear.
    frame_pulse();
    frame_pulse();
    sample();
    check("uflow_set", 64'(UNDERFLOW), 64'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    sample();
    check("uflow_clr", 64'(UNDERFLOW), 64'd0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    sample();
    check("uflow_set_wins", 64'(UNDERFLOW), 64'd1);

    // Commit and frame in the same cycle into an empty FIFO.
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    l_word = rand40();
    r_word = rand40();
    drive(1'b1, l_word, 1'b1, r_word, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    sample();
    check("cf_uflow",   64'(UNDERFLOW),   64'd1);
    check("cf_fill",    64'(FILL),        64'd1);
    check("cf_pdata_l", 64'(bus.PDATA_L), 64'(l_word));
    frame_pulse();
    sample();
    check("cf_popped",  64'(FILL),        64'd0);

    // Random traffic: slow frames first (FIFO fills), then fast (underflows).
    lv = 1'b0; rv = 1'b0; fr = 1'b0; l_word = '0; r_word = '0;
    for (int c = 0; c < 3000; c++) begin
      frame_div = (c < 1500) ? 12 : 3;
      if (!(lv && !acc_l_last)) begin
        lv = ($urandom_range(0, 1) == 1);
        l_word = rand40();
      end
      if (!(rv && !acc_r_last)) begin
        rv = ($urandom_range(0, 1) == 1);
        r_word = rand40();
      end
      fr   = ($urandom_range(0, frame_div) == 0);
      busy = ($urandom_range(0, 4) == 0);
      uclr = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 9) != 0);
      drive(lv, l_word, rv, r_word, fr, busy, uclr, en);
    end
    idle(2);
    sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
